// File: rtl/mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// mem_stage_lsu
//
// Load/store stage between EX and write-back. A result accepted from EX is
// either passed straight through (no memory access), rejected with an
// access_fault strobe (illegal or misaligned access), or turned into a
// handshaked data-memory request that is held until dmem_ack arrives or the
// response timeout expires. Loads are lane-extracted and sign/zero extended
// before being presented to the register file.
//
// Parameters
//   XLEN        data width, 32 or 64
//   ADDR_WIDTH  byte-address width of dmem_addr
//   TIMEOUT     WAIT cycles allowed without dmem_ack before bus_fault (>= 1)
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   valid_i           EX result valid this cycle
//   alu_result        effective address / ALU value
//   mem_read          load request
//   mem_write         store request
//   mem_to_reg        1: write back load data, 0: write back alu_result
//   funct3            RISC-V access size/sign encoding
//   store_data        rs2 value to store
//   stall_o           hold upstream inputs stable
//   dmem_req          memory request, held until ack or timeout
//   dmem_we           1 = write
//   dmem_addr         word-aligned byte address
//   dmem_be           byte enables
//   dmem_wdata        store data replicated into every byte lane
//   dmem_rdata        read data, valid with dmem_ack
//   dmem_ack          one-cycle completion strobe
//   write_back_data   result to register file
//   wb_valid          one-cycle strobe: write_back_data valid
//   access_fault      one-cycle strobe: misaligned or illegal access
//   bus_fault         one-cycle strobe: response timeout
// ---------------------------------------------------------------------------
module mem_stage_lsu #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [XLEN-1:0]       alu_result,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  mem_to_reg,
    input  logic [2:0]            funct3,
    input  logic [XLEN-1:0]       store_data,
    output logic                  stall_o,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [XLEN/8-1:0]     dmem_be,
    output logic [XLEN-1:0]       dmem_wdata,
    input  logic [XLEN-1:0]       dmem_rdata,
    input  logic                  dmem_ack,
    output logic [XLEN-1:0]       write_back_data,
    output logic                  wb_valid,
    output logic                  access_fault,
    output logic                  bus_fault
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int CW   = $clog2(TIMEOUT + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t                state_q, state_n;
    logic [CW-1:0]         cnt_q, cnt_n;
    logic                  we_q, we_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n;
    logic [NB-1:0]         be_q, be_n;
    logic [XLEN-1:0]       wdata_q, wdata_n;
    logic                  load_q, load_n;
    logic                  m2r_q, m2r_n;
    logic [1:0]            size_q, size_n;
    logic                  uns_q, uns_n;
    logic [OFFW-1:0]       off_q, off_n;
    logic [XLEN-1:0]       alu_q, alu_n;
    logic [XLEN-1:0]       wbd_q, wbd_n;
    logic                  wbv_q, wbv_n;
    logic                  af_q, af_n;
    logic                  bf_q, bf_n;

    // Request decode, all taken straight from the EX-side inputs
    logic [1:0]            acc_size;
    logic                  acc_unsigned;
    logic [OFFW-1:0]       acc_off;
    logic                  legal_f3;
    logic [OFFW-1:0]       align_mask;
    logic [NB-1:0]         size_mask;
    logic [NB-1:0]         acc_be;
    logic [XLEN-1:0]       rep_wdata;
    logic [ADDR_WIDTH-1:0] addr_aligned;
    logic                  misaligned;
    logic                  illegal;

    // Load return path
    logic [XLEN-1:0]       lane;
    logic                  sign_bit;
    logic [XLEN-1:0]       load_ext;

    assign acc_size     = funct3[1:0];
    assign acc_unsigned = funct3[2];
    assign acc_off      = alu_result[OFFW-1:0];
    assign addr_aligned = ADDR_WIDTH'(alu_result) & ~ADDR_WIDTH'(NB - 1);

    // Which funct3 codes are real loads/stores depends on XLEN: the double
    // and word-unsigned forms exist only on a 64-bit datapath.
    always_comb begin
        legal_f3 = 1'b0;
        if (mem_read) begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_f3 = 1'b1;
                3'b011, 3'b110:                         legal_f3 = (XLEN == 64);
                default:                                legal_f3 = 1'b0;
            endcase
        end else begin
            case (funct3)
                3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
                3'b011:                 legal_f3 = (XLEN == 64);
                default:                legal_f3 = 1'b0;
            endcase
        end
    end

    // align_mask keeps the low 'size' offset bits, which must all be zero for
    // a naturally aligned access; size_mask has one bit per accessed byte.
    always_comb begin
        align_mask = '0;
        for (int i = 0; i < OFFW; i++) begin
            align_mask[i] = (i < int'(acc_size));
        end
        size_mask = '0;
        for (int i = 0; i < NB; i++) begin
            size_mask[i] = (i < (1 << acc_size));
        end
    end

    assign misaligned = |(acc_off & align_mask);
    assign illegal    = (mem_read & mem_write) | ~legal_f3 | misaligned;
    assign acc_be     = size_mask << acc_off;

    // Replicating the store value across every lane means the memory only has
    // to honour the byte enables; no shifter is needed on the write side.
    always_comb begin
        rep_wdata = store_data;
        case (acc_size)
            2'd0:    rep_wdata = {NB{store_data[7:0]}};
            2'd1:    rep_wdata = {(NB / 2){store_data[15:0]}};
            2'd2:    rep_wdata = {(NB / 4){store_data[31:0]}};
            default: rep_wdata = store_data;
        endcase
    end

    // Shift the addressed lane down to bit 0, then extend from the access
    // width. Only legal sizes ever reach WAIT, so size 3 implies XLEN=64.
    assign lane = dmem_rdata >> {off_q, 3'b000};

    always_comb begin
        case (size_q)
            2'd0:    sign_bit = lane[7];
            2'd1:    sign_bit = lane[15];
            2'd2:    sign_bit = lane[31];
            default: sign_bit = lane[XLEN-1];
        endcase
        load_ext = '0;
        for (int i = 0; i < XLEN; i++) begin
            if (i < (8 << size_q)) begin
                load_ext[i] = lane[i];
            end else begin
                load_ext[i] = ~uns_q & sign_bit;
            end
        end
    end

    // Next-state and next-register logic. Strobes default low so each one
    // lasts exactly one cycle; the request-side registers only change on
    // entering or leaving WAIT, which keeps them stable while the request
    // is outstanding.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        we_n    = we_q;
        addr_n  = addr_q;
        be_n    = be_q;
        wdata_n = wdata_q;
        load_n  = load_q;
        m2r_n   = m2r_q;
        size_n  = size_q;
        uns_n   = uns_q;
        off_n   = off_q;
        alu_n   = alu_q;
        wbd_n   = wbd_q;
        wbv_n   = 1'b0;
        af_n    = 1'b0;
        bf_n    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    if (!mem_read && !mem_write) begin
                        wbv_n = 1'b1;
                        wbd_n = alu_result;
                    end else if (illegal) begin
                        af_n = 1'b1;
                    end else begin
                        state_n = S_WAIT;
                        cnt_n   = '0;
                        we_n    = mem_write;
                        addr_n  = addr_aligned;
                        be_n    = acc_be;
                        wdata_n = mem_write ? rep_wdata : '0;
                        load_n  = mem_read;
                        m2r_n   = mem_to_reg;
                        size_n  = acc_size;
                        uns_n   = acc_unsigned;
                        off_n   = acc_off;
                        alu_n   = alu_result;
                    end
                end
            end

            S_WAIT: begin
                // Ack is tested first so an ack in the final allowed cycle
                // completes normally instead of faulting.
                if (dmem_ack || (cnt_q == CW'(TIMEOUT - 1))) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                    we_n    = 1'b0;
                    addr_n  = '0;
                    be_n    = '0;
                    wdata_n = '0;
                    if (dmem_ack) begin
                        if (load_q) begin
                            wbv_n = 1'b1;
                            wbd_n = m2r_q ? load_ext : alu_q;
                        end
                    end else begin
                        bf_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything, which also
    // abandons any outstanding request so a late ack lands in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            load_q  <= 1'b0;
            m2r_q   <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            off_q   <= '0;
            alu_q   <= '0;
            wbd_q   <= '0;
            wbv_q   <= 1'b0;
            af_q    <= 1'b0;
            bf_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            we_q    <= we_n;
            addr_q  <= addr_n;
            be_q    <= be_n;
            wdata_q <= wdata_n;
            load_q  <= load_n;
            m2r_q   <= m2r_n;
            size_q  <= size_n;
            uns_q   <= uns_n;
            off_q   <= off_n;
            alu_q   <= alu_n;
            wbd_q   <= wbd_n;
            wbv_q   <= wbv_n;
            af_q    <= af_n;
            bf_q    <= bf_n;
        end
    end

    // Stall is masked during reset so every output reads 0 while rst is high.
    assign stall_o = ~rst & (((state_q == S_IDLE) & valid_i & (mem_read | mem_write))
                             | (state_q == S_WAIT));

    assign dmem_req        = (state_q == S_WAIT);
    assign dmem_we         = we_q;
    assign dmem_addr       = addr_q;
    assign dmem_be         = be_q;
    assign dmem_wdata      = wdata_q;
    assign write_back_data = wbd_q;
    assign wb_valid        = wbv_q;
    assign access_fault    = af_q;
    assign bus_fault       = bf_q;

endmodule
